// File: rtl/app_arbit_pkg.sv
// Shared types and helpers for the DDR3 app-port round-robin arbiter.
//   arb_state_t : arbiter FSM states
//   rr_pick_t   : winner index plus valid flag
//   rr_next()   : round-robin search of a pending vector
package app_arbit_pkg;

    localparam int unsigned CH_MAX = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Rotate pend so channel last+1 sits at bit 0, take the lowest set bit,
    // then map that position back to a channel index (all modulo ch_num).
    function automatic rr_pick_t rr_next(
        input logic [CH_MAX-1:0] pend,
        input logic [IDX_W-1:0]  last,
        input int unsigned       ch_num
    );
        rr_pick_t          r;
        logic [CH_MAX-1:0] rot;
        int unsigned       base;
        logic              found;

        r     = '0;
        rot   = '0;
        found = 1'b0;
        base  = (32'(last) + 32'd1) % ch_num;

        for (int unsigned j = 0; j < CH_MAX; j++) begin
            if (j < ch_num) begin
                rot[IDX_W'(j)] = pend[IDX_W'((base + j) % ch_num)];
            end
        end

        for (int unsigned j = 0; j < CH_MAX; j++) begin
            if (!found && rot[IDX_W'(j)]) begin
                found = 1'b1;
                r.vld = 1'b1;
                r.idx = IDX_W'((base + j) % ch_num);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arbit_rr_pick.sv
// Combinational round-robin winner picker.
//   pend      : pending request bits, one per channel
//   last      : index of the most recently granted channel
//   win_id_c  : index of the winning channel
//   win_vld_c : high when any channel is pending
module arbit_rr_pick
    import app_arbit_pkg::*;
#(
    parameter int unsigned CH_NUM = 4
) (
    input  logic [CH_NUM-1:0] pend,
    input  logic [1:0]        last,
    output logic [1:0]        win_id_c,
    output logic              win_vld_c
);

    rr_pick_t pick;

    // Pending vector is zero-extended to the package's maximum channel count.
    assign pick      = rr_next(CH_MAX'(pend), last, CH_NUM);
    assign win_id_c  = pick.idx;
    assign win_vld_c = pick.vld;

endmodule

// File: rtl/app_arbit_rr4.sv
// Round-robin arbiter for the shared DDR3 native app port (2..4 channels).
//   I_clk, I_Rst_n : clock, async active-low reset
//   I_req          : per-channel one-cycle request pulse
//   I_start, I_end : per-channel burst bracket pulses (granted channel only)
//   O_vaild        : one-hot grant, zero when no channel owns the port
//   O_grant_id     : current/last granted channel, drives the command mux
//   O_busy         : high while a channel owns the port
//   O_timeout      : one-cycle pulse when the watchdog forces a release
module app_arbit_rr4
    import app_arbit_pkg::*;
#(
    parameter int unsigned CH_NUM  = 4,
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic              I_clk,
    input  logic              I_Rst_n,
    input  logic [CH_NUM-1:0] I_req,
    input  logic [CH_NUM-1:0] I_start,
    input  logic [CH_NUM-1:0] I_end,
    output logic [CH_NUM-1:0] O_vaild,
    output logic [1:0]        O_grant_id,
    output logic              O_busy,
    output logic              O_timeout
);

    localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [1:0]       ID_RST    = 2'(CH_NUM - 1);

    arb_state_t        state_q,    state_d;
    logic [CH_NUM-1:0] pend_q,     pend_d;
    logic [CH_NUM-1:0] pend_clr;
    logic [CH_NUM-1:0] vaild_q,    vaild_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic              busy_q,     busy_d;
    logic              tmo_q,      tmo_d;
    logic [TMO_W-1:0]  wdog_q,     wdog_d;
    logic [TMO_W-1:0]  wdog_inc;

    logic [1:0]        win_id;
    logic              win_vld;
    logic              hit_start;
    logic              hit_end;
    logic              wdog_exp;

    // Winner search starts just after the last granted channel.
    arbit_rr_pick #(
        .CH_NUM (CH_NUM)
    ) u_pick (
        .pend      (pend_q),
        .last      (grant_id_q),
        .win_id_c  (win_id),
        .win_vld_c (win_vld)
    );

    // vaild_q is one-hot on the owner, so masking ignores foreign pulses.
    assign hit_start = |(I_start & vaild_q);
    assign hit_end   = |(I_end & vaild_q);
    assign wdog_exp  = (wdog_q == WDOG_LAST);
    assign wdog_inc  = wdog_exp ? wdog_q : wdog_q + TMO_W'(1);

    // New requests win over the grant-cycle clear, so a re-request survives.
    assign pend_d = (pend_q & ~pend_clr) | I_req;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        vaild_d    = vaild_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        tmo_d      = 1'b0;
        wdog_d     = wdog_q;
        pend_clr   = '0;

        case (state_q)
            // RELEASE already provided the one-cycle turnaround gap, so it may
            // grant the next pending channel directly.
            ST_IDLE, ST_RELEASE: begin
                vaild_d = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (win_vld) begin
                    state_d    = ST_GRANT;
                    vaild_d    = CH_NUM'(1) << win_id;
                    grant_id_d = win_id;
                    busy_d     = 1'b1;
                    wdog_d     = '0;
                    pend_clr   = CH_NUM'(1) << win_id;
                end
            end

            ST_GRANT: begin
                if (hit_end) begin
                    state_d = ST_RELEASE;
                    vaild_d = '0;
                    busy_d  = 1'b0;
                end else if (wdog_exp) begin
                    state_d = ST_RELEASE;
                    vaild_d = '0;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                end else if (hit_start) begin
                    state_d = ST_BUSY;
                    wdog_d  = '0;
                end else begin
                    wdog_d  = wdog_inc;
                end
            end

            ST_BUSY: begin
                if (hit_end) begin
                    state_d = ST_RELEASE;
                    vaild_d = '0;
                    busy_d  = 1'b0;
                end else if (wdog_exp) begin
                    state_d = ST_RELEASE;
                    vaild_d = '0;
                    busy_d  = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
                vaild_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, pending, watchdog and output registers.
    always_ff @(posedge I_clk or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state_q    <= ST_IDLE;
            pend_q     <= '0;
            vaild_q    <= '0;
            grant_id_q <= ID_RST;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            vaild_q    <= vaild_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            wdog_q     <= wdog_d;
        end
    end

    assign O_vaild    = vaild_q;
    assign O_grant_id = grant_id_q;
    assign O_busy     = busy_q;
    assign O_timeout  = tmo_q;

endmodule

// File: tb/tb_app_arbit_rr4.sv
// Directed bench for app_arbit_rr4 with a grant-order scoreboard.
// Instance a uses a long watchdog for normal bursts; instance b uses a
// 16-cycle watchdog for the forced-release scenario.
module tb_app_arbit_rr4;

    localparam bit DA = 1'b0;
    localparam bit DB = 1'b1;

    logic       clk;
    logic       rst_n;

    logic [3:0] a_req, a_start, a_end, a_vaild;
    logic [1:0] a_grant_id;
    logic       a_busy, a_timeout;

    logic [3:0] b_req, b_start, b_end, b_vaild;
    logic [1:0] b_grant_id;
    logic       b_busy, b_timeout;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    app_arbit_rr4 #(.CH_NUM(4), .TMO_W(16), .TMO_CYC(128)) u_dut_a (
        .I_clk      (clk),
        .I_Rst_n    (rst_n),
        .I_req      (a_req),
        .I_start    (a_start),
        .I_end      (a_end),
        .O_vaild    (a_vaild),
        .O_grant_id (a_grant_id),
        .O_busy     (a_busy),
        .O_timeout  (a_timeout)
    );

    app_arbit_rr4 #(.CH_NUM(4), .TMO_W(16), .TMO_CYC(16)) u_dut_b (
        .I_clk      (clk),
        .I_Rst_n    (rst_n),
        .I_req      (b_req),
        .I_start    (b_start),
        .I_end      (b_end),
        .O_vaild    (b_vaild),
        .O_grant_id (b_grant_id),
        .O_busy     (b_busy),
        .O_timeout  (b_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL tb_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit use_b, input logic [3:0] req, input logic [3:0] st, input logic [3:0] en);
        if (use_b) begin
            b_req = req; b_start = st; b_end = en;
        end else begin
            a_req = req; a_start = st; a_end = en;
        end
    endtask

    task automatic pulse(input bit use_b, input logic [3:0] req, input logic [3:0] st, input logic [3:0] en);
        drive(use_b, req, st, en);
        tick();
        drive(use_b, 4'b0000, 4'b0000, 4'b0000);
    endtask

    // Wait (bounded) for a grant, then pop the expected channel and compare.
    task automatic wait_grant(input bit use_b, input string tag, input int exp_lat);
        int         lat;
        int         ch;
        logic [3:0] v;
        lat = 0;
        v   = use_b ? b_vaild : a_vaild;
        while (v == 4'b0000 && lat < 200) begin
            tick();
            lat++;
            v = use_b ? b_vaild : a_vaild;
        end
        chk({tag, "_sb"}, 32'(exp_q.size() != 0), 32'd1);
        ch = 0;
        if (exp_q.size() != 0) ch = exp_q.pop_front();
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_vaild"}, 32'(v), 32'(4'b0001 << ch));
        chk({tag, "_id"}, 32'(use_b ? b_grant_id : a_grant_id), 32'(ch));
        chk({tag, "_busy"}, 32'(use_b ? b_busy : a_busy), 32'd1);
    endtask

    task automatic chk_idle(input bit use_b, input string tag);
        chk({tag, "_vaild"}, 32'(use_b ? b_vaild : a_vaild), 32'd0);
        chk({tag, "_busy"}, 32'(use_b ? b_busy : a_busy), 32'd0);
    endtask

    initial begin
        logic [3:0] seen;
        int         cnt;

        rst_n = 1'b0;
        drive(DA, 4'b0000, 4'b0000, 4'b0000);
        drive(DB, 4'b0000, 4'b0000, 4'b0000);

        // Reset values
        repeat (3) tick();
        chk_idle(DA, "rst");
        chk("rst_tmo", 32'(a_timeout), 32'd0);
        chk("rst_id_a", 32'(a_grant_id), 32'd3);
        chk("rst_id_b", 32'(b_grant_id), 32'd3);
        rst_n = 1'b1;
        tick();

        // All four request at once: served 0,1,2,3 with a 1-cycle gap
        for (int k = 0; k < 4; k++) exp_q.push_back(k);
        pulse(DA, 4'b1111, 4'b0000, 4'b0000);
        chk("t1_pend_only", 32'(a_vaild), 32'd0);
        for (int k = 0; k < 4; k++) begin
            wait_grant(DA, $sformatf("t1_g%0d", k), 1);
            pulse(DA, 4'b0000, 4'(1 << k), 4'b0000);
            chk($sformatf("t1_busy%0d", k), 32'(a_busy), 32'd1);
            repeat (63) tick();
            pulse(DA, 4'b0000, 4'b0000, 4'(1 << k));
            chk_idle(DA, $sformatf("t1_rel%0d", k));
            chk($sformatf("t1_tmo%0d", k), 32'(a_timeout), 32'd0);
        end
        tick();
        chk_idle(DA, "t1_done");

        // Re-request on the grant edge is kept (set beats clear)
        exp_q.push_back(1);
        exp_q.push_back(1);
        drive(DA, 4'b0010, 4'b0000, 4'b0000);
        tick();
        wait_grant(DA, "sw_g1", 1);
        drive(DA, 4'b0000, 4'b0000, 4'b0000);
        pulse(DA, 4'b0000, 4'b0000, 4'b0010);
        wait_grant(DA, "sw_g2", 1);
        pulse(DA, 4'b0000, 4'b0000, 4'b0010);
        tick();
        chk_idle(DA, "sw_done");

        // Fairness: ch1 and ch0 request while ch1 owns the port -> ch0 then ch1
        exp_q.push_back(1);
        pulse(DA, 4'b0010, 4'b0000, 4'b0000);
        wait_grant(DA, "fair_g1", 1);
        pulse(DA, 4'b0000, 4'b0010, 4'b0000);
        repeat (5) tick();
        exp_q.push_back(0);
        exp_q.push_back(1);
        pulse(DA, 4'b0011, 4'b0000, 4'b0000);
        repeat (5) tick();
        pulse(DA, 4'b0000, 4'b0000, 4'b0010);
        wait_grant(DA, "fair_g0", 1);
        pulse(DA, 4'b0000, 4'b0001, 4'b0000);
        pulse(DA, 4'b0000, 4'b0000, 4'b0001);
        wait_grant(DA, "fair_g1b", 1);
        pulse(DA, 4'b0000, 4'b0000, 4'b0010);
        tick();
        chk_idle(DA, "fair_done");

        // Foreign start/end pulses are ignored while ch0 is busy
        exp_q.push_back(0);
        pulse(DA, 4'b0001, 4'b0000, 4'b0000);
        wait_grant(DA, "frn_g0", 1);
        pulse(DA, 4'b0000, 4'b0001, 4'b0000);
        pulse(DA, 4'b0000, 4'b1000, 4'b0010);
        chk("frn_vaild", 32'(a_vaild), 32'h1);
        chk("frn_busy", 32'(a_busy), 32'd1);
        repeat (3) tick();
        chk("frn_vaild2", 32'(a_vaild), 32'h1);
        pulse(DA, 4'b0000, 4'b0000, 4'b0001);
        chk_idle(DA, "frn_rel");

        // End without start in GRANT releases, no timeout
        exp_q.push_back(0);
        pulse(DA, 4'b0001, 4'b0000, 4'b0000);
        wait_grant(DA, "ens_g0", 1);
        pulse(DA, 4'b0000, 4'b0000, 4'b0001);
        chk_idle(DA, "ens_rel");
        chk("ens_tmo", 32'(a_timeout), 32'd0);

        // Start and end together in GRANT: end wins
        exp_q.push_back(0);
        pulse(DA, 4'b0001, 4'b0000, 4'b0000);
        wait_grant(DA, "se_g0", 1);
        pulse(DA, 4'b0000, 4'b0001, 4'b0001);
        chk_idle(DA, "se_rel");
        tick();
        chk_idle(DA, "se_after");

        // Watchdog (TMO_CYC=16): ch2 never starts, ch3 pending behind it
        exp_q.push_back(2);
        pulse(DB, 4'b1100, 4'b0000, 4'b0000);
        wait_grant(DB, "wd_g2", 1);
        pulse(DB, 4'b0100, 4'b0000, 4'b0000);
        cnt = 1;
        while (b_timeout !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("wd_cycles", 32'(cnt), 32'd16);
        chk_idle(DB, "wd_rel");
        exp_q.push_back(3);
        wait_grant(DB, "wd_g3", 1);
        chk("wd_tmo_low", 32'(b_timeout), 32'd0);
        pulse(DB, 4'b0000, 4'b1000, 4'b0000);
        pulse(DB, 4'b0000, 4'b0000, 4'b1000);
        exp_q.push_back(2);
        wait_grant(DB, "wd_g2b", 1);
        pulse(DB, 4'b0000, 4'b0000, 4'b0100);
        chk_idle(DB, "wd_done");

        // Reset mid-burst drops the grant and pending requests
        exp_q.push_back(2);
        pulse(DA, 4'b0100, 4'b0000, 4'b0000);
        wait_grant(DA, "rb_g2", 1);
        pulse(DA, 4'b0000, 4'b0100, 4'b0000);
        pulse(DA, 4'b1001, 4'b0000, 4'b0000);
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle(DA, "rb_async");
        chk("rb_tmo", 32'(a_timeout), 32'd0);
        chk("rb_id", 32'(a_grant_id), 32'd3);
        tick();
        rst_n = 1'b1;
        seen = 4'b0000;
        repeat (10) begin
            tick();
            seen = seen | a_vaild;
        end
        chk("rb_no_stale_grant", 32'(seen), 32'd0);

        // Normal operation resumes after reset
        exp_q.push_back(2);
        pulse(DA, 4'b0100, 4'b0000, 4'b0000);
        wait_grant(DA, "rb_g2b", 1);
        pulse(DA, 4'b0000, 4'b0000, 4'b0100);
        chk_idle(DA, "rb_done");
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
